seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor: computes `a + b` or `a - b` (as `a + ~b + 1`) over `WIDTH` bits, one `SLICE`-bit ripple-carry slice per clock, with a registered inter-slice carry. It is the sequential, width-generic successor to the 16-bit combinational CPA subtractor. It trades latency for a small adder and sits behind any controller that issues `start` and waits for `done`.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_slice.sv | 30 +++
 rtl/seq_addsub.sv | 126 ++++++++++++
 tb/tb_seq_addsub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2   : ceiling log2, used to size the slice counter
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (overflow detection on the top slice)
module addsub_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE];
    assign cmsb = c[SLICE-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock with a
// registered inter-slice carry. Subtraction is a + ~b + 1.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : request operation (sampled in IDLE or DONE only)
//   sub            : 0 = add, 1 = subtract (latched with operands)
//   a, b           : operands (latched on the accepting edge)
//   busy           : slices being processed
//   done           : one-cycle pulse, result valid from this cycle on
//   s, cout, ovf   : result, carry out of MSB, two's-complement overflow
//   zero           : s == 0
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? clog2(NSLICE) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] areg, breg, acc, acc_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    logic [SLICE-1:0] a_parts [NSLICE];
    logic [SLICE-1:0] b_parts [NSLICE];
    logic [SLICE-1:0] a_sl, b_sl, sum_sl;
    logic             c_out, c_msb;

    always_comb accept = start && (state == IDLE || state == DONE);
    always_comb last   = (cnt == CW'(NSLICE - 1));

    // Slice k of the operands is picked by the counter; the slice sum is
    // written back into the same bit range of the accumulator.
    for (genvar k = 0; k < NSLICE; k++) begin : g_sel
        assign a_parts[k] = areg[k*SLICE +: SLICE];
        assign b_parts[k] = breg[k*SLICE +: SLICE];
        assign acc_nxt[k*SLICE +: SLICE] =
            (cnt == CW'(k)) ? sum_sl : acc[k*SLICE +: SLICE];
    end

    assign a_sl = a_parts[cnt];
    assign b_sl = b_parts[cnt];

    addsub_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .s    (sum_sl),
        .cout (c_out),
        .cmsb (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state == RUN) && last;
            if (accept) begin
                areg  <= a;
                breg  <= b ^ {WIDTH{sub}};
                carry <= sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                carry <= c_out;
                cnt   <= cnt + CW'(1);
                // Outputs take the completed accumulator including the
                // slice being summed on this edge.
                if (last) begin
                    s    <= acc_nxt;
                    cout <= c_out;
                    ovf  <= c_msb ^ c_out;
                    zero <= (acc_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: 16/4 main instance plus 8/8 and 8/1.
module tb_seq_addsub;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int unsigned issue;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // 16-bit, 4-bit slices
    logic        start16, sub16, busy16, done16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, s16;
    // 8-bit, shared stimulus for both slice widths
    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8w, done8w, cout8w, ovf8w, zero8w;
    logic        busy8n, done8n, cout8n, ovf8n, zero8n;
    logic [7:0]  s8w, s8n;

    exp_t q16[$];
    exp_t q8w[$];
    exp_t q8n[$];

    seq_addsub #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    seq_addsub #(.WIDTH(8), .SLICE(8)) dut8w (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8w), .done(done8w), .s(s8w), .cout(cout8w), .ovf(ovf8w), .zero(zero8w)
    );

    seq_addsub #(.WIDTH(8), .SLICE(1)) dut8n (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8n), .done(done8n), .s(s8n), .cout(cout8n), .ovf(ovf8n), .zero(zero8n)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [15:0] s, logic c, logic o, logic z);
        exp_t e;
        e.s = s; e.cout = c; e.ovf = o; e.zero = z; e.issue = 0; e.lat = 0;
        return e;
    endfunction

    // Reference: overflow from operand/result signs, carry from a wide sum.
    function automatic exp_t model(int unsigned w, logic [15:0] a, logic [15:0] b, logic sub);
        exp_t e;
        int unsigned mask, ai, bi, bb, r;
        logic sa, sb, sr;
        mask = (32'd1 << w) - 1;
        ai = 32'(a) & mask;
        bi = 32'(b) & mask;
        bb = sub ? (~bi & mask) : bi;
        r = ai + bb + 32'(sub);
        e.s = 16'(r & mask);
        e.cout = r[w];
        sa = ai[w-1]; sb = bi[w-1]; sr = e.s[w-1];
        e.ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.zero = (e.s == 16'h0);
        e.issue = 0; e.lat = 0;
        return e;
    endfunction

    // Monitors: pop and compare whenever a DUT presents done.
    exp_t m16, m8w, m8n;
    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("done16_unexpected", 32'd1, 32'd0);
            end else begin
                m16 = q16.pop_front();
                check("s16",    {16'h0, s16},   {16'h0, m16.s});
                check("cout16", {31'h0, cout16}, {31'h0, m16.cout});
                check("ovf16",  {31'h0, ovf16},  {31'h0, m16.ovf});
                check("zero16", {31'h0, zero16}, {31'h0, m16.zero});
                check("lat16",  cyc - m16.issue, m16.lat);
                check("busy16_at_done", {31'h0, busy16}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done8w === 1'b1) begin
            if (q8w.size() == 0) begin
                check("done8w_unexpected", 32'd1, 32'd0);
            end else begin
                m8w = q8w.pop_front();
                check("s8w",    {24'h0, s8w},    {16'h0, m8w.s});
                check("cout8w", {31'h0, cout8w}, {31'h0, m8w.cout});
                check("ovf8w",  {31'h0, ovf8w},  {31'h0, m8w.ovf});
                check("zero8w", {31'h0, zero8w}, {31'h0, m8w.zero});
                check("lat8w",  cyc - m8w.issue, m8w.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (done8n === 1'b1) begin
            if (q8n.size() == 0) begin
                check("done8n_unexpected", 32'd1, 32'd0);
            end else begin
                m8n = q8n.pop_front();
                check("s8n",    {24'h0, s8n},    {16'h0, m8n.s});
                check("cout8n", {31'h0, cout8n}, {31'h0, m8n.cout});
                check("ovf8n",  {31'h0, ovf8n},  {31'h0, m8n.ovf});
                check("zero8n", {31'h0, zero8n}, {31'h0, m8n.zero});
                check("lat8n",  cyc - m8n.issue, m8n.lat);
            end
        end
    end

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input bit push, input exp_t e);
        exp_t x;
        @(negedge clk);
        a16 = a; b16 = b; sub16 = sub; start16 = 1'b1;
        if (push) begin
            x = e; x.issue = cyc + 1; x.lat = 4;
            q16.push_back(x);
        end
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sub, input exp_t e);
        exp_t x;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        x = e; x.issue = cyc + 1;
        x.lat = 1; q8w.push_back(x);
        x.lat = 8; q8n.push_back(x);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_all();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q16.size() == 0 && q8w.size() == 0 && q8n.size() == 0) return;
        end
        check("done_timeout", 32'd1, 32'd0);
        q16.delete(); q8w.delete(); q8n.delete();
    endtask

    task automatic check_reset16(input string tag);
        check({tag, "_s"},    {16'h0, s16},   32'd0);
        check({tag, "_cout"}, {31'h0, cout16}, 32'd0);
        check({tag, "_ovf"},  {31'h0, ovf16},  32'd0);
        check({tag, "_zero"}, {31'h0, zero16}, 32'd1);
        check({tag, "_busy"}, {31'h0, busy16}, 32'd0);
        check({tag, "_done"}, {31'h0, done16}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        exp_t        e;

        rst = 1'b1;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start8 = 1'b0;  sub8 = 1'b0;  a8 = '0;  b8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset16("rst16");
        check("rst8w_zero", {31'h0, zero8w}, 32'd1);
        check("rst8n_s", {24'h0, s8n}, 32'd0);

        // Add with busy profile: high for the 4 cycles after acceptance
        issue16(16'h1234, 16'h0001, 1'b0, 1'b1, mk(16'h1235, 1'b0, 1'b0, 1'b0));
        check("busy16_c1", {31'h0, busy16}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check("busy16_run", {31'h0, busy16}, 32'd1);
        end
        wait_all();

        issue16(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        wait_all();
        issue16(16'h1234, 16'h1234, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        wait_all();
        issue16(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        wait_all();
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        wait_all();

        // start mid-RUN with new operands is ignored
        issue16(16'h0100, 16'h0200, 1'b0, 1'b1, mk(16'h0300, 1'b0, 1'b0, 1'b0));
        a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_all();
        repeat (6) @(negedge clk);
        check("hold16_s", {16'h0, s16}, 32'h0300);

        // start held through DONE: second op accepted 5 edges after the first
        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0002; sub16 = 1'b0; start16 = 1'b1;
        e = mk(16'h0003, 1'b0, 1'b0, 1'b0); e.issue = cyc + 1; e.lat = 4;
        q16.push_back(e);
        @(negedge clk);
        a16 = 16'h0010; b16 = 16'h0003; sub16 = 1'b1;
        e = mk(16'h000D, 1'b1, 1'b0, 1'b0); e.issue = e.issue; e.issue = q16[0].issue + 5; e.lat = 4;
        q16.push_back(e);
        repeat (5) @(negedge clk);
        start16 = 1'b0;
        wait_all();

        // Reset in RUN cycle 2: outputs drop at once, no done follows
        issue16(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset16("midrst16");
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst16_nodone_s", {16'h0, s16}, 32'd0);

        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        wait_all();

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            issue16(ra, rb, rs, 1'b1, model(16, ra, rb, rs));
            wait_all();
        end

        // 8-bit: SLICE=8 (latency 1) and SLICE=1 (latency 8)
        issue8(8'hFF, 8'h01, 1'b0, mk(16'h00, 1'b1, 1'b0, 1'b1));
        wait_all();
        issue8(8'h80, 8'h01, 1'b1, mk(16'h7F, 1'b1, 1'b1, 1'b0));
        wait_all();
        issue8(8'h05, 8'h07, 1'b1, mk(16'hFE, 1'b0, 1'b0, 1'b0));
        wait_all();
        issue8(8'h7F, 8'h01, 1'b0, mk(16'h80, 1'b0, 1'b1, 1'b0));
        wait_all();
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); rs = 1'($urandom);
            issue8(ra[7:0], rb[7:0], rs, model(8, ra, rb, rs));
            wait_all();
        end

        repeat (4) @(negedge clk);
        check("q_empty", 32'(q16.size() + q8w.size() + q8n.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
